// File: rtl/pipe_cla_pkg.sv
// rtl/pipe_cla_pkg.sv - shared ALU constants: default datapath geometry and stage derivation
package pipe_cla_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_BLOCK = 8;

    // One pipeline stage per carry-lookahead slice.
    function automatic int alu_stages(input int width, input int block);
        return width / block;
    endfunction

endpackage

// File: rtl/cla_block.sv
// rtl/cla_block.sv - combinational BLOCK-bit generate/propagate carry-lookahead adder slice
module cla_block
    import pipe_cla_pkg::*;
#(
    parameter int BLOCK = ALU_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);

    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is expanded as a flat sum of products of g/p/cin, never chained
    // through the previous carry.
    always_comb begin
        logic chain;
        chain = 1'b0;
        c     = '0;
        c[0]  = cin;
        for (int i = 0; i < BLOCK; i++) begin
            chain    = p[i];
            c[i + 1] = g[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i + 1] = c[i + 1] | (chain & g[j]);
                chain    = chain & p[j];
            end
            c[i + 1] = c[i + 1] | (chain & cin);
        end
    end

    assign sum  = p ^ c[BLOCK-1:0];
    assign cout = c[BLOCK];

endmodule

// File: rtl/pipe_cla.sv
// rtl/pipe_cla.sv - pipelined add/subtract, one CLA slice per stage with operand skew and result deskew
module pipe_cla
    import pipe_cla_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int BLOCK = ALU_BLOCK
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_sub,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_result,
    output logic             cout,
    output logic             overflow
);

    localparam int STAGES = alu_stages(WIDTH, BLOCK);

    logic [WIDTH-1:0] eff_b;
    logic             eff_cin;

    assign eff_b   = ctrl_sub ? ~data_operandB : data_operandB;
    assign eff_cin = ctrl_sub | cin;

    // Stage k registers only the operand slices still waiting (k+1 and up) and the
    // sum slices already produced (0..k), so the skew/deskew shrinks/grows per stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int AW = WIDTH - k * BLOCK;
        localparam int SW = (k + 1) * BLOCK;

        logic [AW-1:0]    a_in;
        logic [AW-1:0]    b_in;
        logic             c_in;
        logic             v_in;
        logic [BLOCK-1:0] sum;
        logic             co;
        logic [SW-1:0]    s_all;

        if (k == 0) begin : g_first
            assign a_in  = data_operandA;
            assign b_in  = eff_b;
            assign c_in  = eff_cin;
            assign v_in  = in_valid;
            assign s_all = sum;
        end else begin : g_next
            assign a_in  = g_stage[k-1].g_mid.a_r;
            assign b_in  = g_stage[k-1].g_mid.b_r;
            assign c_in  = g_stage[k-1].g_mid.c_r;
            assign v_in  = g_stage[k-1].g_mid.v_r;
            assign s_all = {sum, g_stage[k-1].g_mid.s_r};
        end

        cla_block #(.BLOCK(BLOCK)) u_cla (
            .a    (a_in[BLOCK-1:0]),
            .b    (b_in[BLOCK-1:0]),
            .cin  (c_in),
            .sum  (sum),
            .cout (co)
        );

        if (k < STAGES - 1) begin : g_mid
            logic [AW-BLOCK-1:0] a_r;
            logic [AW-BLOCK-1:0] b_r;
            logic [SW-1:0]       s_r;
            logic                c_r;
            logic                v_r;

            always_ff @(posedge clock) begin
                if (reset) begin
                    a_r <= '0;
                    b_r <= '0;
                    s_r <= '0;
                    c_r <= 1'b0;
                    v_r <= 1'b0;
                end else if (enable) begin
                    a_r <= a_in[AW-1:BLOCK];
                    b_r <= b_in[AW-1:BLOCK];
                    s_r <= s_all;
                    c_r <= co;
                    v_r <= v_in;
                end
            end
        end else begin : g_last
            // Result fields are forced to zero for bubbles so idle outputs read as 0.
            always_ff @(posedge clock) begin
                if (reset) begin
                    out_valid   <= 1'b0;
                    data_result <= '0;
                    cout        <= 1'b0;
                    overflow    <= 1'b0;
                end else if (enable) begin
                    out_valid   <= v_in;
                    data_result <= v_in ? s_all : '0;
                    cout        <= v_in & co;
                    overflow    <= v_in & (a_in[AW-1] == b_in[AW-1]) & (s_all[SW-1] != a_in[AW-1]);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_cla.sv
// tb/tb_pipe_cla.sv - directed and random checks of pipe_cla against an arithmetic reference
module tb_pipe_cla;

    localparam int W = 32;
    localparam int S = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic         in_valid;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic         ctrl_sub;
    logic         cin;
    logic         out_valid;
    logic [W-1:0] data_result;
    logic         cout;
    logic         overflow;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int nv       = 0;

    logic [34:0] pipe[$];
    logic [34:0] cur = '0;

    pipe_cla #(.WIDTH(W), .BLOCK(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .in_valid      (in_valid),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_sub      (ctrl_sub),
        .cin           (cin),
        .out_valid     (out_valid),
        .data_result   (data_result),
        .cout          (cout),
        .overflow      (overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    function automatic logic [34:0] ref_op(input logic v, input logic [31:0] a, input logic [31:0] b,
                                           input logic s, input logic c);
        logic [32:0] wide;
        logic [31:0] r;
        logic        co;
        longint      la;
        longint      lb;
        longint      sv;
        if (!v) return '0;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (s) begin
            r  = a - b;
            co = (a >= b);
            sv = la - lb;
        end else begin
            wide = {1'b0, a} + {1'b0, b} + {32'b0, c};
            r    = wide[31:0];
            co   = wide[32];
            sv   = la + lb + longint'(c);
        end
        return {1'b1, co, (sv > 64'sd2147483647) || (sv < -64'sd2147483648), r};
    endfunction

    function automatic logic [34:0] obs();
        return {out_valid, cout, overflow, data_result};
    endfunction

    task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic s, input logic c);
        reset         = rst;
        enable        = en;
        in_valid      = v;
        data_operandA = a;
        data_operandB = b;
        ctrl_sub      = s;
        cin           = c;
        @(posedge clock);
        if (rst) begin
            pipe.delete();
            for (int i = 0; i < S - 1; i++) pipe.push_back('0);
            cur = '0;
        end else if (en) begin
            pipe.push_back(ref_op(v, a, b, s, c));
            if (pipe.size() > S) void'(pipe.pop_front());
            cur = pipe[0];
        end
        @(negedge clock);
        check("pipe_model", obs(), cur);
        if (en && !rst && out_valid) nv++;
    endtask

    task automatic rnd(input logic en);
        step(1'b0, en, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b1, 1'b1, 1'b1, 32'h1234, 32'h5678, 1'b0, 1'b0);
        check("reset_1", obs(), 35'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("reset_2", obs(), 35'h0);

        step(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1);
        idle();
        idle();
        idle();
        check("full_ripple", obs(), {3'b110, 32'h00000000});

        step(1'b0, 1'b1, 1'b1, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h5, 32'h7, 1'b1, 1'b1);
        idle();
        idle();
        check("add_overflow", obs(), {3'b101, 32'h80000000});
        idle();
        check("sub_negative", obs(), {3'b100, 32'hFFFFFFFE});

        nv = 0;
        for (int i = 0; i < 10; i++) rnd(1'b1);
        for (int i = 0; i < 4; i++) idle();
        check("b2b_count", 35'(nv), 35'd10);

        nv = 0;
        for (int i = 0; i < 3; i++) rnd(1'b1);
        for (int i = 0; i < 3; i++) rnd(1'b0);
        for (int i = 0; i < 3; i++) rnd(1'b1);
        for (int i = 0; i < 4; i++) idle();
        check("stall_count", 35'(nv), 35'd6);

        for (int i = 0; i < 3; i++) rnd(1'b1);
        step(1'b1, 1'b1, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
        check("flush_reset", obs(), 35'h0);
        nv = 0;
        step(1'b0, 1'b1, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
        idle();
        idle();
        check("flush_quiet", 35'(nv), 35'd0);
        idle();
        check("post_reset_op", obs(), {3'b100, 32'h00000003});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_cla.md
PIPE_CLA -- requirements
Module: pipe_cla

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 SHALL have parameter BLOCK, default 8, meaning bits per CLA slice; WIDTH SHALL be a multiple of BLOCK.
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1, meaning pipeline advance; low stalls every stage.
REQ-006 SHALL have port in_valid, input, 1, meaning the operands on this cycle are a real operation.
REQ-007 SHALL have port data_operandA, input, WIDTH, meaning operand A.
REQ-008 SHALL have port data_operandB, input, WIDTH, meaning operand B.
REQ-009 SHALL have port ctrl_sub, input, 1, meaning 1 = A - B, 0 = A + B + cin.
REQ-010 SHALL have port cin, input, 1, meaning carry-in for add; ignored when ctrl_sub = 1.
REQ-011 SHALL have port out_valid, output, 1, meaning the result outputs are valid this cycle.
REQ-012 SHALL have port data_result, output, WIDTH, meaning the sum/difference modulo 2^WIDTH.
REQ-013 SHALL have port cout, output, 1, meaning carry out of bit WIDTH-1.
REQ-014 SHALL have port overflow, output, 1, meaning two's-complement signed overflow.

Function
REQ-015 SHALL split the datapath into STAGES = WIDTH/BLOCK pipeline stages; stage k adds slice k (bits k*BLOCK .. k*BLOCK+BLOCK-1) with full internal carry lookahead and registers that slice's carry-out for stage k+1.
REQ-016 SHALL skew input slices so slice k enters its adder exactly k cycles after capture, and deskew result slices so all WIDTH bits of one operation are presented together.
REQ-017 SHALL produce results with a latency of exactly STAGES enabled cycles: an operation captured on enabled edge n appears on the outputs after enabled edge n+STAGES-1 (STAGES=4 for the defaults).
REQ-018 SHALL accept one operation per enabled cycle with no bubbles; out_valid SHALL equal in_valid delayed by STAGES enabled cycles.
REQ-019 SHALL, for subtraction, use effective B = ~data_operandB and effective carry-in = 1.
REQ-020 SHALL set overflow = 1 exactly when A[WIDTH-1] equals effective B[WIDTH-1] and data_result[WIDTH-1] differs from them.
REQ-021 SHALL, when enable = 0, hold all pipeline registers and all outputs unchanged, including out_valid; inputs presented that cycle are not captured.
REQ-022 SHALL drive data_result, cout and overflow to 0 whenever out_valid = 0.
REQ-023 SHALL give reset precedence over enable when both are high.

Reset
REQ-024 SHALL, on a clock edge with reset = 1, clear every valid bit, skew/deskew register and inter-stage carry to 0, so that out_valid, data_result, cout and overflow are 0 on the following cycle.
REQ-025 SHALL discard all in-flight operations on reset; none SHALL emerge afterward.
REQ-026 SHALL capture a new operation on the first enabled edge with reset = 0.

Structure
REQ-027 SHALL place the default WIDTH/BLOCK values and the STAGES derivation in the shared ALU constants header used by the ALU blocks.
REQ-028 SHALL instantiate STAGES copies of one combinational sub-module, cla_block (BLOCK-bit generate/propagate lookahead adder with carry-in, sum and carry-out).
REQ-029 SHALL contain no combinational path from any input to any output.

Verification
REQ-030 SHALL cover: reset asserted 2 cycles -> out_valid, data_result, cout, overflow all 0.
REQ-031 SHALL cover: A=0xFFFFFFFF, B=0x00000000, cin=1, add -> 4 cycles later data_result=0x00000000, cout=1, overflow=0 (full carry ripple across all stages).
REQ-032 SHALL cover: A=0x7FFFFFFF, B=0x00000001, cin=0, add -> data_result=0x80000000, cout=0, overflow=1; and sub A=5, B=7 -> data_result=0xFFFFFFFE, cout=0, overflow=0.
REQ-033 SHALL cover: 10 back-to-back random operations (in_valid=1 every cycle, random cin/ctrl_sub) -> 10 consecutive out_valid cycles, each equal to A+B+cin or A-B modulo 2^32.
REQ-034 SHALL cover: enable low for 3 cycles mid-stream -> outputs frozen for those 3 cycles, then the stream resumes in order with no loss or duplication.
REQ-035 SHALL cover: reset pulsed 1 cycle with 3 operations in flight -> no out_valid for those operations; the next operation emerges with latency 4.
